fetch_stage: RTL and testbench

- Instruction-fetch stage; sits directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues word fetches to instruction memory, one request outstanding at a time.
- Buffers returned instructions in a small FIFO so that ID stalls do not lose data.
- Presents instruction, currPC and pc_plus4 to IF/ID, and accepts branch redirects from downstream.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_buf.sv | 47 ++++
 rtl/fetch_stage.sv | 135 +++++++++++++
 tb/tb_fetch_stage.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned PC_W        = 64;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO of fetched {instr, pc} entries; DEPTH must be a power of two.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  fetch_entry_t     entry_i,
  input  logic             pop_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q < CNT_W'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem requests, credit-managed buffer.
// Optional perf counters fetch_count/bubble_count when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [63:0] currPC,
  output logic [63:0] pc_plus4,
  output logic        out_valid,
  output logic        IF_ID_flush
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`endif
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic             flush_q;
  logic [31:0]      hold_instr_q;
  logic [PC_W-1:0]  hold_pc_q, hold_pc4_q;

  fetch_entry_t     head, push_entry;
  logic [CNT_W-1:0] count;
  logic             in_flight, has_credit, push, pop;
  logic [PC_W-1:0]  head_pc4;

  assign in_flight  = (state_q != IDLE);
  assign has_credit = (count + CNT_W'(in_flight)) < CNT_W'(BUF_DEPTH);
  assign out_valid  = (count != '0);
  assign pop        = out_valid && !stall && !redirect;
  assign push       = (state_q == WAIT) && imem_rvalid && !redirect;
  assign push_entry = '{instr: imem_rdata, pc: fetch_pc_q};

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk_i   (clk),
    .reset_i (reset),
    .clear_i (redirect),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    imem_req   = 1'b0;
    unique case (state_q)
      IDLE: begin
        imem_req = has_credit && !redirect && !reset;
        if (imem_req && imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d    = IDLE;
          fetch_pc_d = fetch_pc_q + PC_W'(INSTR_BYTES);
        end
      end
      DRAIN: begin
        if (imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A redirect overrides everything; an outstanding response still owed must be drained.
    if (redirect) begin
      fetch_pc_d = {redirect_pc[63:2], 2'b00};
      state_d    = (in_flight && !imem_rvalid) ? DRAIN : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      flush_q      <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      hold_pc4_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      flush_q    <= redirect;
      if (out_valid) begin
        hold_instr_q <= head.instr;
        hold_pc_q    <= head.pc;
        hold_pc4_q   <= head_pc4;
      end
    end
  end

  assign head_pc4    = head.pc + PC_W'(INSTR_BYTES);
  assign imem_addr   = fetch_pc_q;
  assign IF_ID_flush = flush_q;
  assign instruction = out_valid ? head.instr : hold_instr_q;
  assign currPC      = out_valid ? head.pc    : hold_pc_q;
  assign pc_plus4    = out_valid ? head_pc4   : hold_pc4_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (push && (fetch_cnt_q != '1)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (!out_valid && !stall && (bubble_cnt_q != '1)) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fetch_count  = fetch_cnt_q;
  assign bubble_count = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a variable-latency memory model.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [31:0] instruction;
  logic [63:0] currPC;
  logic [63:0] pc_plus4;
  logic        out_valid;
  logic        IF_ID_flush;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  fetch_stage #(
    .RESET_PC  (64'd0),
    .BUF_DEPTH (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instruction (instruction),
    .currPC      (currPC),
    .pc_plus4    (pc_plus4),
    .out_valid   (out_valid),
    .IF_ID_flush (IF_ID_flush)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count  (fetch_count),
    .bubble_count (bubble_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: grants immediately, answers mem_lat cycles after the grant cycle.
  int          mem_lat = 1;
  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [63:0] mem_addr = '0;
  logic        s_gnt, s_rv, s_rst;
  logic [63:0] s_addr;

  assign imem_gnt = imem_req;

  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
  end

  always @(posedge clk) begin
    s_gnt  = imem_req && imem_gnt;
    s_rv   = imem_rvalid;
    s_rst  = reset;
    s_addr = imem_addr;
    #1;
    if (s_rst) begin
      mem_pend = 1'b0;
    end else begin
      if (s_rv) mem_pend = 1'b0;
      if (s_gnt) begin
        mem_pend = 1'b1;
        mem_cnt  = mem_lat;
        mem_addr = s_addr;
      end else if (mem_pend) begin
        mem_cnt = mem_cnt - 1;
      end
    end
    imem_rvalid = mem_pend && (mem_cnt == 1);
    imem_rdata  = 32'hC0DE_0000 ^ mem_addr[31:0];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Leaves the bench 1 time unit into cycle 0 (first cycle with reset low).
  task automatic do_reset(input int lat);
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    mem_lat     = lat;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req",   imem_req,    0);
    check("rst_valid", out_valid,   0);
    check("rst_flush", IF_ID_flush, 0);
    check("rst_instr", instruction, 0);
    check("rst_pc",    currPC,      0);
    check("rst_pc4",   pc_plus4,    0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    // Basic streaming, 1-cycle memory
    do_reset(1);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      case (c)
        0: begin check("t1_req0", imem_req, 1); check("t1_addr0", imem_addr, 64'h0); end
        1: begin check("t1_req1", imem_req, 0); check("t1_valid1", out_valid, 0); end
        2: begin
          check("t1_valid2", out_valid, 1);
          check("t1_pc2", currPC, 64'h0);
          check("t1_pc4_2", pc_plus4, 64'h4);
          check("t1_instr2", instruction, 32'hC0DE_0000);
          check("t1_addr2", imem_addr, 64'h4);
        end
        3: begin check("t1_valid3", out_valid, 0); check("t1_hold3", currPC, 64'h0); end
        4: begin
          check("t1_pc4", currPC, 64'h4);
          check("t1_pc4_4", pc_plus4, 64'h8);
          check("t1_addr4", imem_addr, 64'h8);
        end
        6: begin
          check("t1_pc6", currPC, 64'h8);
          check("t1_pc4_6", pc_plus4, 64'hC);
          check("t1_instr6", instruction, 32'hC0DE_0008);
        end
        default: ;
      endcase
      @(posedge clk);
      #1;
    end

    // Stall fills the buffer, then drains in order
    do_reset(1);
    for (int c = 0; c <= 9; c++) begin
      stall = (c < 6);
      @(negedge clk);
      case (c)
        2: begin check("t2_req2", imem_req, 1); check("t2_addr2", imem_addr, 64'h4); end
        4: begin check("t2_req4", imem_req, 0); check("t2_valid4", out_valid, 1); check("t2_pc4", currPC, 64'h0); end
        5: begin check("t2_req5", imem_req, 0); check("t2_pc5", currPC, 64'h0); end
        6: begin check("t2_pc6", currPC, 64'h0); check("t2_instr6", instruction, 32'hC0DE_0000); check("t2_req6", imem_req, 0); end
        7: begin check("t2_pc7", currPC, 64'h4); check("t2_req7", imem_req, 1); check("t2_addr7", imem_addr, 64'h8); end
        8: check("t2_valid8", out_valid, 0);
        9: begin check("t2_valid9", out_valid, 1); check("t2_pc9", currPC, 64'h8); end
        default: ;
      endcase
      @(posedge clk);
      #1;
    end
    stall = 1'b0;

    // Redirect while waiting on 3-cycle memory
    do_reset(3);
    for (int c = 0; c <= 12; c++) begin
      stall       = (c <= 5);
      redirect    = (c == 5);
      redirect_pc = 64'h200;
      @(negedge clk);
      case (c)
        4: begin
          check("t3_valid4", out_valid, 1);
          check("t3_pc4", currPC, 64'h0);
          check("t3_req4", imem_req, 1);
          check("t3_addr4", imem_addr, 64'h4);
        end
        5: check("t3_valid5", out_valid, 1);
        6: begin
          check("t3_flush6", IF_ID_flush, 1);
          check("t3_valid6", out_valid, 0);
          check("t3_req6", imem_req, 0);
          check("t3_hold6", currPC, 64'h0);
        end
        7: begin check("t3_flush7", IF_ID_flush, 0); check("t3_valid7", out_valid, 0); check("t3_req7", imem_req, 0); end
        8: begin check("t3_req8", imem_req, 1); check("t3_addr8", imem_addr, 64'h200); end
        11: check("t3_valid11", out_valid, 0);
        12: begin
          check("t3_valid12", out_valid, 1);
          check("t3_pc12", currPC, 64'h200);
          check("t3_pc4_12", pc_plus4, 64'h204);
          check("t3_instr12", instruction, 32'hC0DE_0200);
        end
        default: ;
      endcase
      @(posedge clk);
      #1;
    end
    redirect = 1'b0;
    stall    = 1'b0;

    // Redirect coinciding with a response and a pop; low PC bits masked
    do_reset(1);
    for (int c = 0; c <= 6; c++) begin
      stall       = (c < 3);
      redirect    = (c == 3);
      redirect_pc = 64'h106;
      @(negedge clk);
      case (c)
        3: begin check("t4_valid3", out_valid, 1); check("t4_pc3", currPC, 64'h0); end
        4: begin
          check("t4_flush4", IF_ID_flush, 1);
          check("t4_valid4", out_valid, 0);
          check("t4_req4", imem_req, 1);
          check("t4_addr4", imem_addr, 64'h104);
          check("t4_hold4", currPC, 64'h0);
        end
        5: begin check("t4_flush5", IF_ID_flush, 0); check("t4_valid5", out_valid, 0); end
        6: begin
          check("t4_valid6", out_valid, 1);
          check("t4_pc6", currPC, 64'h104);
          check("t4_pc4_6", pc_plus4, 64'h108);
          check("t4_instr6", instruction, 32'hC0DE_0104);
        end
        default: ;
      endcase
      @(posedge clk);
      #1;
    end
    redirect = 1'b0;

    // PC wrap at the top of the address space
    do_reset(1);
    for (int c = 0; c <= 5; c++) begin
      redirect    = (c == 0);
      redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
      @(negedge clk);
      case (c)
        0: check("t5_req0", imem_req, 0);
        1: begin
          check("t5_flush1", IF_ID_flush, 1);
          check("t5_req1", imem_req, 1);
          check("t5_addr1", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        end
        3: begin
          check("t5_valid3", out_valid, 1);
          check("t5_pc3", currPC, 64'hFFFF_FFFF_FFFF_FFFC);
          check("t5_pc4_3", pc_plus4, 64'h0);
          check("t5_instr3", instruction, 32'h3F21_FFFC);
          check("t5_req3", imem_req, 1);
          check("t5_addr3", imem_addr, 64'h0);
        end
        5: begin check("t5_pc5", currPC, 64'h0); check("t5_pc4_5", pc_plus4, 64'h4); end
        default: ;
      endcase
      @(posedge clk);
      #1;
    end
    redirect = 1'b0;

`ifdef FETCH_PERF_CNT_EN
    // Counters after startup: out_valid pattern 0,0,1,0,1,... with pushes on odd cycles
    do_reset(1);
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      case (c)
        0: begin check("t6_fetch0", fetch_count, 0); check("t6_bub0", bubble_count, 0); end
        2: begin check("t6_fetch2", fetch_count, 1); check("t6_bub2", bubble_count, 2); end
        10: begin check("t6_fetch10", fetch_count, 5); check("t6_bub10", bubble_count, 6); end
        default: ;
      endcase
      @(posedge clk);
      #1;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
